hazard_scheduler: RTL
=====================

Name: hazard_scheduler

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Tracks in-flight destination registers in the E and M stages using Tuse/Tnew records. Asserts a stall that freezes PC/IF-ID and bubbles the ID/EX register; `flush_e` drives ID/EX `stop_sel`.
- Also sequences the multi-cycle mult/div unit and stalls any HI/LO-using instruction until that unit is idle.
- Sits beside the decoder in D; D-stage fields come from the decoder.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu leaves E.
- DIV_CYCLES, 10, busy cycles after a div/divu leaves E.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- d_valid  in  1  D holds a real instruction (0 = bubble, never hazards).
- d_rs  in  5  rs address read by the D instruction.
- d_rt  in  5  rt address read by the D instruction.
- d_tuse_rs  in  2  Tuse of rs: 0 for beq/jr, 1 for ALU/address, 3 for unused.
- d_tuse_rt  in  2  Tuse of rt: 0 for beq, 1 for ALU, 2 for sw data, 3 for unused.
- d_wa  in  5  destination register (0 = none).
- d_tnew  in  2  Tnew when entering E: 0 for lui/jal, 1 for ALU, 2 for lw.
- d_md_start  in  1  D is mult/multu/div/divu.
- d_md_div  in  1  with d_md_start: 1 = div, 0 = mult.
- d_md_use  in  1  D is mfhi/mflo/mthi/mtlo/mult/div.
- stall  out  1  hold PC and IF/ID.
- flush_e  out  1  load a bubble into ID/EX; always equals stall.
- md_busy  out  1  mult/div unit occupied.
- md_cnt  out  4  remaining busy cycles.
- stall_cnt  out  32  count of stalled cycles, wraps at 2^32.

Behaviour:
- State:
  - E record {e_wa[4:0], e_tnew[1:0], e_md_start, e_md_div}.
  - M record {m_wa, m_tnew}.
  - md_cnt and stall_cnt.
- Reset (reset==0 at posedge): all records, md_cnt and stall_cnt become 0. Consequently stall=0, flush_e=0, md_busy=0 after the reset edge. Reset mid-div abandons the operation (md_cnt=0).
- Record update each posedge (not in reset):
  - E record: if stall or !d_valid, E is loaded with zeros; else E <= {d_wa, d_tnew, d_md_start, d_md_div}.
  - M record: m_wa <= e_wa; m_tnew <= (e_tnew==0) ? 0 : e_tnew-1 (saturating).
- Register hazard (combinational), for each source r in {rs, rt} with its Tuse t:
  - hz_r = d_valid && r!=0 && t!=3 && ((e_wa==r && e_tnew>t) || (m_wa==r && m_tnew>t)).
  - e_wa==0 and m_wa==0 never match, because r!=0.
- Mult/div sequencing:
  - md_busy = e_md_start || md_cnt!=0.
  - At a posedge with e_md_start=1, md_cnt loads DIV_CYCLES if e_md_div, else MULT_CYCLES.
  - Otherwise md_cnt decrements when nonzero, saturating at 0.
  - hz_md = d_valid && d_md_use && md_busy.
- Outputs:
  - stall = hz_rs | hz_rt | hz_md; flush_e = stall. Both are combinational with no added latency.
  - stall_cnt increments at every posedge where stall==1.
- Simultaneous events:
  - A register hazard and an md hazard together produce a single stall.
  - A new mult/div in D while busy is itself a d_md_use instruction, so it stalls; it never restarts md_cnt mid-operation.
- A stalled D instruction re-evaluates every cycle. stall deasserts in the first cycle no hazard remains.

Test Plan:
- Reset held low 2 cycles with arbitrary inputs -> stall=0, md_busy=0, md_cnt=0, stall_cnt=0.
- lw $1 (wa=1, tnew=2) then add using rt=$1 (tuse 1) -> exactly 1 stall cycle; stall_cnt=1.
- lw $1 then beq rs=$1 (tuse 0) -> 2 consecutive stall cycles.
- add $2 (tnew=1) then beq rs=$2 -> 1 stall; add $2 then sw rt=$2 (tuse 2) -> 0 stalls.
- lw $0 then add rs=$0, and lw $1 then lui (tuse 3) -> 0 stalls.
- mult in D at cycle N, mflo in D at N+1 -> stall high N+1..N+6 (6 cycles); md_cnt=5 at N+2 counting to 0 at N+7; stall low at N+7.
- div issued, then reset low for one cycle at md_cnt=7 -> md_cnt=0, md_busy=0 next cycle; a following mfhi does not stall.

Source files
------------

// File: rtl/hazard_scheduler.sv
// D-stage hazard scheduler: Tuse/Tnew stall detection against the E/M records,
// plus sequencing of the multi-cycle mult/div unit that HI/LO users wait on.
module hazard_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_valid,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [1:0]  d_tuse_rs,
  input  logic [1:0]  d_tuse_rt,
  input  logic [4:0]  d_wa,
  input  logic [1:0]  d_tnew,
  input  logic        d_md_start,
  input  logic        d_md_div,
  input  logic        d_md_use,
  output logic        stall,
  output logic        flush_e,
  output logic        md_busy,
  output logic [3:0]  md_cnt,
  output logic [31:0] stall_cnt
);
  localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

  typedef struct packed {
    logic [4:0] wa;
    logic [1:0] tnew;
    logic       md_start;
    logic       md_div;
  } e_rec_t;

  typedef struct packed {
    logic [4:0] wa;
    logic [1:0] tnew;
  } m_rec_t;

  e_rec_t      e_q, e_d;
  m_rec_t      m_q, m_d;
  logic [3:0]  md_cnt_q, md_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        hz_rs, hz_rt, hz_md;

  // A source is hazardous while a producer ahead of it cannot deliver by its Tuse.
  function automatic logic src_hz(input logic [4:0] r, input logic [1:0] t,
                                  input e_rec_t e, input m_rec_t m);
    return (r != 5'd0) && (t != 2'd3) &&
           (((e.wa == r) && (e.tnew > t)) || ((m.wa == r) && (m.tnew > t)));
  endfunction

  always_comb begin
    hz_rs   = d_valid && src_hz(d_rs, d_tuse_rs, e_q, m_q);
    hz_rt   = d_valid && src_hz(d_rt, d_tuse_rt, e_q, m_q);
    md_busy = e_q.md_start || (md_cnt_q != 4'd0);
    hz_md   = d_valid && d_md_use && md_busy;
    stall   = hz_rs | hz_rt | hz_md;
    flush_e = stall;
  end

  always_comb begin
    e_d = '0;
    if (!stall && d_valid) e_d = '{wa: d_wa, tnew: d_tnew, md_start: d_md_start, md_div: d_md_div};
    m_d.wa   = e_q.wa;
    m_d.tnew = (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;
    md_cnt_d = md_cnt_q;
    if (e_q.md_start)            md_cnt_d = e_q.md_div ? DIV_LD : MULT_LD;
    else if (md_cnt_q != 4'd0)   md_cnt_d = md_cnt_q - 4'd1;
    stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      e_q         <= '0;
      m_q         <= '0;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      m_q         <= m_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign md_cnt    = md_cnt_q;
  assign stall_cnt = stall_cnt_q;
endmodule
